// File: rtl/mainmemory_pipe.sv
// Line-granular main memory with pipelined reads,
// credit-based ready and a sticky protocol-error flag.
module mainmemory_pipe #(
  parameter int LINE_W     = 256,
  parameter int ADDR_W     = 27,
  parameter int ENTRIES    = 1024,
  parameter int READ_LAT   = 1,
  parameter int WRITE_TPUT = 1,
  parameter int MAX_OUT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a,
  input  logic [LINE_W-1:0] wd,
  input  logic              read,
  input  logic              write,
  output logic [LINE_W-1:0] rd,
  output logic              valid,
  output logic              ready,
  output logic              err
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int WB_W  = $clog2(WRITE_TPUT) + 1;
  localparam int OC_W  = $clog2(MAX_OUT + 1);

  localparam logic [WB_W-1:0] WB_LOAD = WB_W'(WRITE_TPUT - 1);
  localparam logic [OC_W-1:0] OC_MAX  = OC_W'(MAX_OUT);

  logic [LINE_W-1:0] mem [ENTRIES];
  logic [LINE_W-1:0] pd  [READ_LAT];
  logic [READ_LAT-1:0] pv;
  logic [LINE_W-1:0] rd_q;
  logic [WB_W-1:0]   wbusy;
  logic [OC_W-1:0]   outstanding;
  logic [IDX_W-1:0]  idx;
  logic              acc_rd;
  logic              acc_wr;
  logic              bad;
  logic              unused_a;

  assign idx      = a[IDX_W-1:0];
  assign unused_a = ^a;

  assign valid = pv[READ_LAT-1];
  assign rd    = valid ? pd[READ_LAT-1] : rd_q;

  // A returning read frees its credit in its own valid cycle.
  assign ready = (wbusy == '0) &&
                 ((outstanding < OC_MAX) || valid);

  assign acc_wr = reset & write & ~read & ready;
  assign acc_rd = reset & read & ~write & ready;
  assign bad    = reset & ((read & write) |
                  ((read | write) & ~ready));

  always_ff @(posedge clk) begin
    if (acc_wr) begin
      mem[idx] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    pd[0] <= mem[idx];
    for (int i = 1; i < READ_LAT; i++) begin
      pd[i] <= pd[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0;
    end else begin
      pv[0] <= acc_rd;
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i] <= pv[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q        <= '0;
      wbusy       <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      rd_q <= rd;
      err  <= err | bad;
      if (acc_wr) begin
        wbusy <= WB_LOAD;
      end else if (wbusy != '0) begin
        wbusy <= wbusy - WB_W'(1);
      end
      unique case ({acc_rd, valid})
        2'b10:   outstanding <= outstanding + OC_W'(1);
        2'b01:   outstanding <= outstanding - OC_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_mainmemory_pipe.sv
// Directed bench for mainmemory_pipe across four
// parameter sets sharing one clock and reset.
module tb_mainmemory_pipe;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [26:0] a  [4];
  logic [31:0] wd [4];
  logic        rq [4];
  logic        wq [4];
  logic [31:0] rd [4];
  logic        valid [4];
  logic        ready [4];
  logic        err [4];

  int checks = 0;
  int errors = 0;

  mainmemory_pipe #(
    .LINE_W(32), .ENTRIES(16), .READ_LAT(1),
    .WRITE_TPUT(1), .MAX_OUT(1)
  ) u0 (
    .clk(clk), .reset(reset), .a(a[0]), .wd(wd[0]),
    .read(rq[0]), .write(wq[0]), .rd(rd[0]),
    .valid(valid[0]), .ready(ready[0]), .err(err[0])
  );

  mainmemory_pipe #(
    .LINE_W(32), .ENTRIES(16), .READ_LAT(4),
    .WRITE_TPUT(1), .MAX_OUT(4)
  ) u1 (
    .clk(clk), .reset(reset), .a(a[1]), .wd(wd[1]),
    .read(rq[1]), .write(wq[1]), .rd(rd[1]),
    .valid(valid[1]), .ready(ready[1]), .err(err[1])
  );

  mainmemory_pipe #(
    .LINE_W(32), .ENTRIES(16), .READ_LAT(4),
    .WRITE_TPUT(1), .MAX_OUT(2)
  ) u2 (
    .clk(clk), .reset(reset), .a(a[2]), .wd(wd[2]),
    .read(rq[2]), .write(wq[2]), .rd(rd[2]),
    .valid(valid[2]), .ready(ready[2]), .err(err[2])
  );

  mainmemory_pipe #(
    .LINE_W(32), .ENTRIES(16), .READ_LAT(1),
    .WRITE_TPUT(3), .MAX_OUT(1)
  ) u3 (
    .clk(clk), .reset(reset), .a(a[3]), .wd(wd[3]),
    .read(rq[3]), .write(wq[3]), .rd(rd[3]),
    .valid(valid[3]), .ready(ready[3]), .err(err[3])
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic drv(input int i, input logic r,
                     input logic w,
                     input logic [26:0] ad,
                     input logic [31:0] d);
    rq[i] = r;
    wq[i] = w;
    a[i]  = ad;
    wd[i] = d;
  endtask

  int er [11] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1};
  int ev [11] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
  logic [31:0] edat [11] = '{0, 0, 0, 0,
    32'h200, 32'h201, 0, 0, 32'h202, 32'h203, 0};

  initial begin
    int acc;
    for (int i = 0; i < 4; i++) drv(i, 0, 0, 0, 0);
    repeat (2) nx();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_ready%0d", i), ready[i], 1);
      chk($sformatf("rst_valid%0d", i), valid[i], 0);
      chk($sformatf("rst_rd%0d", i), rd[i], 0);
      chk($sformatf("rst_err%0d", i), err[i], 0);
    end
    reset = 1'b1;

    // basic write then read, latency 1
    drv(0, 0, 1, 27'h5, 32'hA5A5A5A5);
    nx();
    chk("b_ready", ready[0], 1);
    drv(0, 1, 0, 27'h5, 0);
    nx();
    chk("b_valid", valid[0], 1);
    chk("b_rd", rd[0], 32'hA5A5A5A5);
    drv(0, 0, 0, 0, 0);
    nx();
    chk("b_valid_off", valid[0], 0);
    chk("b_rd_hold", rd[0], 32'hA5A5A5A5);
    chk("b_err", err[0], 0);

    // alias and read+write conflict
    drv(0, 0, 1, 27'h13, 32'h12345678);
    nx();
    drv(0, 1, 0, 27'h03, 0);
    nx();
    chk("al_valid", valid[0], 1);
    chk("al_rd", rd[0], 32'h12345678);
    drv(0, 1, 1, 27'h03, 32'hDEADBEEF);
    nx();
    chk("cf_err", err[0], 1);
    chk("cf_valid", valid[0], 0);
    drv(0, 1, 0, 27'h03, 0);
    nx();
    chk("cf_valid2", valid[0], 1);
    chk("cf_rd", rd[0], 32'h12345678);
    drv(0, 0, 0, 0, 0);
    nx();
    chk("cf_err_stick", err[0], 1);

    // pipelined reads, latency 4, credit 4
    for (int k = 0; k < 4; k++) begin
      drv(1, 0, 1, 27'(k), 32'h100 + 32'(k));
      nx();
    end
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("pl_ready%0d", k), ready[1], 1);
      chk($sformatf("pl_valid%0d", k), valid[1],
          64'((k >= 4) && (k < 8)));
      if (k >= 4 && k < 8)
        chk($sformatf("pl_rd%0d", k), rd[1],
            32'h100 + 32'(k - 4));
      if (k < 4) drv(1, 1, 0, 27'(k), 0);
      else       drv(1, 0, 0, 0, 0);
      nx();
    end
    chk("pl_err", err[1], 0);

    // credit limit, latency 4, credit 2
    for (int k = 0; k < 4; k++) begin
      drv(2, 0, 1, 27'(k), 32'h200 + 32'(k));
      nx();
    end
    drv(2, 0, 0, 0, 0);
    acc = 0;
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("cr_ready%0d", k), ready[2], 64'(er[k]));
      chk($sformatf("cr_valid%0d", k), valid[2], 64'(ev[k]));
      if (ev[k] == 1)
        chk($sformatf("cr_rd%0d", k), rd[2], edat[k]);
      if (er[k] == 1 && acc < 4) begin
        drv(2, 1, 0, 27'(acc), 0);
        acc++;
      end else begin
        drv(2, 0, 0, 0, 0);
      end
      nx();
    end
    chk("cr_err0", err[2], 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) chk("cr_ready_lo", ready[2], 0);
      if (k < 3) drv(2, 1, 0, 0, 0);
      else       drv(2, 0, 0, 0, 0);
      if (k == 3) chk("cr_err1", err[2], 1);
      nx();
    end
    repeat (6) nx();
    chk("cr_err_stick", err[2], 1);
    chk("cr_ready_back", ready[2], 1);

    // write throughput 3
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("wt_ready%0d", k), ready[3],
          64'(k % 3 == 0));
      if (k % 3 == 0)
        drv(3, 0, 1, 27'h7, 32'h300 + 32'(k / 3));
      else
        drv(3, 0, 0, 0, 0);
      nx();
    end
    chk("wt_ready9", ready[3], 1);
    drv(3, 1, 0, 27'h7, 0);
    nx();
    chk("wt_valid", valid[3], 1);
    chk("wt_rd", rd[3], 32'h302);
    chk("wt_err", err[3], 0);
    drv(3, 0, 0, 0, 0);

    // asynchronous reset with reads in flight
    drv(1, 1, 0, 27'h1, 0);
    nx();
    drv(1, 1, 0, 27'h2, 0);
    nx();
    drv(1, 0, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", valid[1], 0);
    chk("ar_rd", rd[1], 0);
    chk("ar_err", err[1], 0);
    chk("ar_ready", ready[1], 1);
    chk("ar_err2", err[2], 0);
    nx();
    nx();
    reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("ar_v%0d", k), valid[1], 64'(k == 4));
      if (k == 4) chk("ar_rd_keep", rd[1], 32'h101);
      if (k == 0) drv(1, 1, 0, 27'h1, 0);
      else        drv(1, 0, 0, 0, 0);
      nx();
    end
    chk("ar_ready_end", ready[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
